// File: rtl/y_mc_pkg.sv
// Shared encodings for the multi-cycle sequencer: state codes, opcode classes
// and the PC-source / writeback-source selects.
package y_mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Bit positions inside the one-hot class vector
  localparam int CLS_W   = 6;
  localparam int CLS_R   = 0;
  localparam int CLS_I   = 1;
  localparam int CLS_LW  = 2;
  localparam int CLS_SW  = 3;
  localparam int CLS_BR  = 4;
  localparam int CLS_JAL = 5;

  typedef logic [CLS_W-1:0] cls_t;

  localparam logic [1:0] PC_P4    = 2'b00;
  localparam logic [1:0] PC_BR    = 2'b01;
  localparam logic [1:0] PC_JMP   = 2'b10;
  localparam logic [1:0] PC_ENTRY = 2'b11;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

endpackage

// File: rtl/y_mc_decode.sv
// Combinational opcode classifier: one-hot class plus an illegal flag for any
// opcode outside the supported set.
module y_mc_decode
  import y_mc_pkg::*;
(
  input  logic [6:0] opCode,
  output cls_t       cls,
  output logic       illegal
);

  // Map opcode to its one-hot class
  always_comb begin
    cls     = '0;
    illegal = 1'b0;
    case (opCode)
      OP_R:    cls[CLS_R]   = 1'b1;
      OP_I:    cls[CLS_I]   = 1'b1;
      OP_LW:   cls[CLS_LW]  = 1'b1;
      OP_SW:   cls[CLS_SW]  = 1'b1;
      OP_BR:   cls[CLS_BR]  = 1'b1;
      OP_JAL:  cls[CLS_JAL] = 1'b1;
      default: illegal      = 1'b1;
    endcase
  end

endmodule

// File: rtl/y_mc_ctrl.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP over one shared,
// handshaked memory port, with a retired-instruction counter.
module y_mc_ctrl
  import y_mc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opCode,
  input  logic             zero,
  input  logic             INT,
  input  logic             memReady,
  output logic             pcWrite,
  output logic [1:0]       pcSel,
  output logic             irWrite,
  output logic             IorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             regWrite,
  output logic             ALUSrc,
  output logic [1:0]       ALUop,
  output logic [1:0]       wbSel,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_t           state_r, state_nx_s;
  cls_t             cls_r, dec_cls_s;
  logic             dec_illegal_s;
  logic             req_r, req_nx_s;
  logic             in_reset_r;
  logic             retire_s;
  logic [CNT_W-1:0] instret_r;

  logic       pcwrite_s, irwrite_s, iord_s, memread_s, memwrite_s;
  logic       regwrite_s, alusrc_s, illegal_s;
  logic [1:0] pcsel_s, aluop_s, wbsel_s;

  y_mc_decode u_decode (
    .opCode  (opCode),
    .cls     (dec_cls_s),
    .illegal (dec_illegal_s)
  );

  // State, latched class, outstanding-fetch flag and retirement counter.
  // in_reset_r blanks every output for the cycle(s) following a reset edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_FETCH;
      cls_r      <= '0;
      req_r      <= 1'b0;
      in_reset_r <= 1'b1;
      instret_r  <= '0;
    end else if (in_reset_r) begin
      state_r    <= ST_FETCH;
      req_r      <= 1'b0;
      in_reset_r <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      req_r   <= req_nx_s;
      if (state_r == ST_DECODE) begin
        cls_r <= dec_cls_s;
      end
      if (retire_s) begin
        instret_r <= instret_r + CNT_W'(1);
      end
    end
  end

  // Next-state and per-state strobe decode
  always_comb begin
    state_nx_s = state_r;
    req_nx_s   = 1'b0;
    retire_s   = 1'b0;
    pcwrite_s  = 1'b0;
    pcsel_s    = PC_P4;
    irwrite_s  = 1'b0;
    iord_s     = 1'b0;
    memread_s  = 1'b0;
    memwrite_s = 1'b0;
    regwrite_s = 1'b0;
    alusrc_s   = 1'b0;
    aluop_s    = 2'b00;
    wbsel_s    = WB_ALU;
    illegal_s  = 1'b0;
    case (state_r)
      ST_FETCH: begin
        // INT only counts before the fetch request has gone out
        if (!req_r && INT) begin
          state_nx_s = ST_TRAP;
        end else begin
          memread_s = 1'b1;
          if (memReady) begin
            irwrite_s  = 1'b1;
            pcwrite_s  = 1'b1;
            pcsel_s    = PC_P4;
            state_nx_s = ST_DECODE;
          end else begin
            req_nx_s = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (dec_illegal_s) begin
          illegal_s  = 1'b1;
          state_nx_s = ST_FETCH;
        end else begin
          state_nx_s = ST_EXEC;
        end
      end
      ST_EXEC: begin
        aluop_s  = {cls_r[CLS_R], cls_r[CLS_BR]};
        alusrc_s = cls_r[CLS_I] | cls_r[CLS_LW] | cls_r[CLS_SW];
        if (cls_r[CLS_R] || cls_r[CLS_I]) begin
          state_nx_s = ST_WB;
        end else if (cls_r[CLS_LW] || cls_r[CLS_SW]) begin
          state_nx_s = ST_MEM;
        end else if (cls_r[CLS_BR]) begin
          pcwrite_s  = zero;
          pcsel_s    = zero ? PC_BR : PC_P4;
          retire_s   = 1'b1;
          state_nx_s = ST_FETCH;
        end else if (cls_r[CLS_JAL]) begin
          pcwrite_s  = 1'b1;
          pcsel_s    = PC_JMP;
          state_nx_s = ST_WB;
        end else begin
          state_nx_s = ST_FETCH;
        end
      end
      ST_MEM: begin
        iord_s     = 1'b1;
        memread_s  = cls_r[CLS_LW];
        memwrite_s = cls_r[CLS_SW];
        if (memReady) begin
          retire_s   = cls_r[CLS_SW];
          state_nx_s = cls_r[CLS_LW] ? ST_WB : ST_FETCH;
        end else begin
          state_nx_s = ST_MEM;
        end
      end
      ST_WB: begin
        regwrite_s = 1'b1;
        wbsel_s    = cls_r[CLS_LW] ? WB_MEM : (cls_r[CLS_JAL] ? WB_PC4 : WB_ALU);
        retire_s   = 1'b1;
        state_nx_s = ST_FETCH;
      end
      ST_TRAP: begin
        pcwrite_s  = 1'b1;
        pcsel_s    = PC_ENTRY;
        state_nx_s = ST_FETCH;
      end
      default: begin
        state_nx_s = ST_FETCH;
      end
    endcase
  end

  assign pcWrite  = pcwrite_s  & ~in_reset_r;
  assign pcSel    = in_reset_r ? 2'b00 : pcsel_s;
  assign irWrite  = irwrite_s  & ~in_reset_r;
  assign IorD     = iord_s     & ~in_reset_r;
  assign memRead  = memread_s  & ~in_reset_r;
  assign memWrite = memwrite_s & ~in_reset_r;
  assign regWrite = regwrite_s & ~in_reset_r;
  assign ALUSrc   = alusrc_s   & ~in_reset_r;
  assign ALUop    = in_reset_r ? 2'b00 : aluop_s;
  assign wbSel    = in_reset_r ? 2'b00 : wbsel_s;
  assign illegal  = illegal_s  & ~in_reset_r;
  assign state    = in_reset_r ? 3'd0 : state_r;
  assign instret  = instret_r;

endmodule
